exe_operand_bypass: RTL and testbench

- EXE-stage operand bypass network; sits directly downstream of the forwarding-decision unit and consumes its four registered forward flags.
- Holds a 2-deep history of results produced by the two older in-flight instructions (EXE-ahead slot, MEM slot).
- Muxes those results or register-file read data onto the ALU operands.
- Tracks outstanding load results and raises a pipeline stall on load-use dependencies.

---
 rtl/exe_operand_bypass.sv | 141 ++++++++++++++
 tb/tb_exe_operand_bypass.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/exe_operand_bypass.sv
// EXE-stage operand bypass: 2-deep result history, operand muxing and load-use stall.
// Optional statistics counters are built only when BYPASS_STATS_EN is defined.
module exe_operand_bypass #(
    parameter int DATA_W  = 32,
    parameter int STATS_W = 16
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [DATA_W-1:0]  rs_data_in,
    input  logic [DATA_W-1:0]  rt_data_in,
    input  logic               fwd_exe_rs,
    input  logic               fwd_exe_rt,
    input  logic               fwd_mem_rs,
    input  logic               fwd_mem_rt,
    input  logic [DATA_W-1:0]  alu_result,
    input  logic               exe_writes,
    input  logic               exe_is_load,
    input  logic [DATA_W-1:0]  load_data,
    input  logic               load_valid,
    input  logic               advance,
    output logic [DATA_W-1:0]  op_a,
    output logic [DATA_W-1:0]  op_b,
    output logic               op_valid,
    output logic               stall,
    output logic [STATS_W-1:0] fwd_count,
    output logic [STATS_W-1:0] stall_count
);

    // State bit 0 is pend0 (slot 0 awaiting load data), bit 1 is pend1 (slot 1).
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_P0    = 2'b01,
        ST_P1    = 2'b10,
        ST_P01   = 2'b11
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_hist0;
    logic [DATA_W-1:0] r_hist1;
    logic              w_pend0;
    logic              w_pend1;
    logic              w_stall;
    logic              w_adv;
    logic              w_new_load;

    assign w_pend0    = r_state[0];
    assign w_pend1    = r_state[1];
    assign w_adv      = advance & ~w_stall;
    assign w_new_load = exe_writes & exe_is_load;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A load returning in the same cycle slot 0 shifts out lands directly in slot 1.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_adv && w_new_load) w_state_nxt = ST_P0;
            end
            ST_P0: begin
                if (w_adv) begin
                    if (w_new_load) w_state_nxt = load_valid ? ST_P0 : ST_P01;
                    else            w_state_nxt = load_valid ? ST_EMPTY : ST_P1;
                end else if (load_valid) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_P1: begin
                if (load_valid) w_state_nxt = ST_EMPTY;
            end
            ST_P01: begin
                if (load_valid) w_state_nxt = ST_P0;
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    always_comb begin
        w_stall  = w_pend1 | (w_pend0 & (fwd_exe_rs | fwd_exe_rt));
        stall    = w_stall;
        op_valid = ~w_stall;
        op_a     = fwd_exe_rs ? r_hist0 : (fwd_mem_rs ? r_hist1 : rs_data_in);
        op_b     = fwd_exe_rt ? r_hist0 : (fwd_mem_rt ? r_hist1 : rt_data_in);
    end

    // Load data is written into the oldest pending slot before any shift is applied.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_hist0 <= '0;
            r_hist1 <= '0;
        end else if (w_adv) begin
            r_hist1 <= (w_pend0 && load_valid) ? load_data : r_hist0;
            r_hist0 <= exe_is_load ? '0 : alu_result;
        end else if (load_valid) begin
            if (w_pend1) begin
                r_hist1 <= load_data;
            end else if (w_pend0) begin
                r_hist0 <= load_data;
            end
        end
    end

`ifdef BYPASS_STATS_EN
    logic [STATS_W-1:0] r_fwd_count;
    logic [STATS_W-1:0] r_stall_count;
    logic [1:0]         w_fwd_inc;

    function automatic logic [STATS_W-1:0] sat_add(input logic [STATS_W-1:0] base,
                                                   input logic [1:0]         inc);
        logic [STATS_W:0] sum;
        sum = {1'b0, base} + {{(STATS_W - 1){1'b0}}, inc};
        return sum[STATS_W] ? {STATS_W{1'b1}} : sum[STATS_W-1:0];
    endfunction

    assign w_fwd_inc = {1'b0, fwd_exe_rs | fwd_mem_rs} + {1'b0, fwd_exe_rt | fwd_mem_rt};

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_fwd_count   <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_adv)   r_fwd_count   <= sat_add(r_fwd_count, w_fwd_inc);
            if (w_stall) r_stall_count <= sat_add(r_stall_count, 2'd1);
        end
    end

    assign fwd_count   = r_fwd_count;
    assign stall_count = r_stall_count;
`else
    assign fwd_count   = '0;
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_exe_operand_bypass.sv
// Directed, table-driven bench for exe_operand_bypass with hand-written reset corner case.
module tb_exe_operand_bypass;
    localparam int DATA_W  = 32;
    localparam int STATS_W = 16;

    logic               CLK = 1'b0;
    logic               RESET;
    logic [DATA_W-1:0]  rs_data_in, rt_data_in, alu_result, load_data;
    logic               fwd_exe_rs, fwd_exe_rt, fwd_mem_rs, fwd_mem_rt;
    logic               exe_writes, exe_is_load, load_valid, advance;
    logic [DATA_W-1:0]  op_a, op_b;
    logic               op_valid, stall;
    logic [STATS_W-1:0] fwd_count, stall_count;

    exe_operand_bypass #(.DATA_W(DATA_W), .STATS_W(STATS_W)) dut (
        .CLK(CLK), .RESET(RESET),
        .rs_data_in(rs_data_in), .rt_data_in(rt_data_in),
        .fwd_exe_rs(fwd_exe_rs), .fwd_exe_rt(fwd_exe_rt),
        .fwd_mem_rs(fwd_mem_rs), .fwd_mem_rt(fwd_mem_rt),
        .alu_result(alu_result), .exe_writes(exe_writes), .exe_is_load(exe_is_load),
        .load_data(load_data), .load_valid(load_valid), .advance(advance),
        .op_a(op_a), .op_b(op_b), .op_valid(op_valid), .stall(stall),
        .fwd_count(fwd_count), .stall_count(stall_count)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_fwd  = 0;
    int exp_stc  = 0;

    // fwd bits: {exe_rs, exe_rt, mem_rs, mem_rt}
    typedef struct {
        logic [3:0]  fwd;
        logic [31:0] alu;
        logic        wr;
        logic        ld;
        logic [31:0] ldd;
        logic        lv;
        logic        adv;
        logic [31:0] ea;
        logic [31:0] eb;
        logic        es;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [3:0] fwd, input logic [31:0] alu, input logic wr,
                                input logic ld, input logic [31:0] ldd, input logic lv,
                                input logic adv, input logic [31:0] ea, input logic [31:0] eb,
                                input logic es);
        vec_t v;
        v.fwd = fwd; v.alu = alu; v.wr = wr; v.ld = ld; v.ldd = ldd;
        v.lv = lv; v.adv = adv; v.ea = ea; v.eb = eb; v.es = es;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rs_data_in  = 32'h11;
        rt_data_in  = 32'h22;
        {fwd_exe_rs, fwd_exe_rt, fwd_mem_rs, fwd_mem_rt} = v.fwd;
        alu_result  = v.alu;
        exe_writes  = v.wr;
        exe_is_load = v.ld;
        load_data   = v.ldd;
        load_valid  = v.lv;
        advance     = v.adv;
    endtask

    task automatic check_outputs(input string tag, input vec_t v);
        check({tag, ".op_a"}, op_a, v.ea);
        check({tag, ".op_b"}, op_b, v.eb);
        check({tag, ".stall"}, {31'd0, stall}, {31'd0, v.es});
        check({tag, ".op_valid"}, {31'd0, op_valid}, {31'd0, ~v.es});
    endtask

    task automatic check_counters(input string tag);
`ifdef BYPASS_STATS_EN
        check({tag, ".fwd_count"}, {16'd0, fwd_count}, exp_fwd[31:0]);
        check({tag, ".stall_count"}, {16'd0, stall_count}, exp_stc[31:0]);
`else
        check({tag, ".fwd_count"}, {16'd0, fwd_count}, 32'd0);
        check({tag, ".stall_count"}, {16'd0, stall_count}, 32'd0);
`endif
    endtask

    initial begin
        vec_t v;
        // Basic forwarding, slot priority
        tbl.push_back(mk(4'h0, 32'h0,        0, 0, 32'h0, 0, 0, 32'h11,       32'h22,       0));
        tbl.push_back(mk(4'h0, 32'hAAAA0001, 1, 0, 32'h0, 0, 1, 32'h11,       32'h22,       0));
        tbl.push_back(mk(4'h8, 32'h5,        1, 0, 32'h0, 0, 1, 32'hAAAA0001, 32'h22,       0));
        tbl.push_back(mk(4'h1, 32'h0,        0, 0, 32'h0, 0, 0, 32'h11,       32'hAAAA0001, 0));
        tbl.push_back(mk(4'h0, 32'h9,        1, 0, 32'h0, 0, 1, 32'h11,       32'h22,       0));
        tbl.push_back(mk(4'h0, 32'h5,        1, 0, 32'h0, 0, 1, 32'h11,       32'h22,       0));
        tbl.push_back(mk(4'hB, 32'h0,        0, 0, 32'h0, 0, 0, 32'h5,        32'h9,        0));
        // Load-use stall on slot 0, four stall cycles
        tbl.push_back(mk(4'h0, 32'hFFFF,     1, 1, 32'h0, 0, 1, 32'h11,       32'h22,       0));
        tbl.push_back(mk(4'h4, 32'h77,       1, 0, 32'h0, 0, 1, 32'h11,       32'h0,        1));
        tbl.push_back(mk(4'h4, 32'h77,       1, 0, 32'h0, 0, 1, 32'h11,       32'h0,        1));
        tbl.push_back(mk(4'h4, 32'h77,       1, 0, 32'h0, 0, 1, 32'h11,       32'h0,        1));
        tbl.push_back(mk(4'h4, 32'h77,       1, 0, 32'hDEADBEEF, 1, 1, 32'h11, 32'h0,       1));
        tbl.push_back(mk(4'h4, 32'h77,       1, 0, 32'h0, 0, 1, 32'h11,       32'hDEADBEEF, 0));
        // Load leaves slot 0 unreturned: P1 stalls regardless of flags
        tbl.push_back(mk(4'h0, 32'h3,        1, 1, 32'h0, 0, 1, 32'h11,       32'h22,       0));
        tbl.push_back(mk(4'h0, 32'h44,       1, 0, 32'h0, 0, 1, 32'h11,       32'h22,       0));
        tbl.push_back(mk(4'h0, 32'h55,       1, 0, 32'h0, 0, 1, 32'h11,       32'h22,       1));
        tbl.push_back(mk(4'h2, 32'h55,       1, 0, 32'h0, 0, 1, 32'h0,        32'h22,       1));
        tbl.push_back(mk(4'h0, 32'h55,       1, 0, 32'h1234, 1, 1, 32'h11,    32'h22,       1));
        tbl.push_back(mk(4'h6, 32'h0,        0, 0, 32'h0, 0, 0, 32'h1234,     32'h44,       0));
        // Same-cycle advance and load return from P0
        tbl.push_back(mk(4'h0, 32'h3,        1, 1, 32'h0, 0, 1, 32'h11,       32'h22,       0));
        tbl.push_back(mk(4'h0, 32'h66,       1, 0, 32'hCAFE, 1, 1, 32'h11,    32'h22,       0));
        tbl.push_back(mk(4'h6, 32'h0,        0, 0, 32'h0, 0, 0, 32'hCAFE,     32'h66,       0));
        // Spurious load_valid with nothing pending
        tbl.push_back(mk(4'h9, 32'h0,        0, 0, 32'hBAD, 1, 0, 32'h66,     32'hCAFE,     0));
        tbl.push_back(mk(4'h9, 32'h0,        0, 0, 32'h0, 0, 0, 32'h66,       32'hCAFE,     0));
        // Two loads back to back: P01 -> P0 -> EMPTY
        tbl.push_back(mk(4'h0, 32'h3,        1, 1, 32'h0, 0, 1, 32'h11,       32'h22,       0));
        tbl.push_back(mk(4'h0, 32'h3,        1, 1, 32'h0, 0, 1, 32'h11,       32'h22,       0));
        tbl.push_back(mk(4'h0, 32'h0,        0, 0, 32'h0, 0, 1, 32'h11,       32'h22,       1));
        tbl.push_back(mk(4'h0, 32'h0,        0, 0, 32'h111, 1, 1, 32'h11,     32'h22,       1));
        tbl.push_back(mk(4'h2, 32'h0,        0, 0, 32'h0, 0, 0, 32'h111,      32'h22,       0));
        tbl.push_back(mk(4'h4, 32'h0,        0, 0, 32'h0, 0, 0, 32'h11,       32'h0,        1));
        tbl.push_back(mk(4'h4, 32'h0,        0, 0, 32'h222, 1, 0, 32'h11,     32'h0,        1));
        tbl.push_back(mk(4'h4, 32'h0,        0, 0, 32'h0, 0, 0, 32'h11,       32'h222,      0));

        RESET = 1'b0;
        drive(tbl[0]);
        @(negedge CLK);
        @(negedge CLK);
        check_outputs("reset", tbl[0]);
        check_counters("reset");
        RESET = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge CLK);
            drive(tbl[i]);
            #2;
            check_outputs($sformatf("row%0d", i), tbl[i]);
            check_counters($sformatf("row%0d", i));
            if (tbl[i].adv && !tbl[i].es)
                exp_fwd += int'(tbl[i].fwd[3] | tbl[i].fwd[1]) + int'(tbl[i].fwd[2] | tbl[i].fwd[0]);
            if (tbl[i].es) exp_stc++;
        end

        // Reach P01, then drop reset asynchronously mid-cycle
        v = mk(4'h0, 32'h3, 1, 1, 32'h0, 0, 1, 32'h11, 32'h22, 0);
        @(negedge CLK); drive(v);
        @(negedge CLK); drive(v);
        @(negedge CLK);
        v = mk(4'h0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h11, 32'h22, 1);
        drive(v);
        #2;
        check_outputs("p01", v);
        RESET = 1'b0;
        v = mk(4'hC, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0);
        drive(v);
        #1;
        check_outputs("mid_reset", v);
        exp_fwd = 0;
        exp_stc = 0;
        check_counters("mid_reset");

        @(negedge CLK);
        RESET = 1'b1;
        v = mk(4'h0, 32'h0, 0, 0, 32'h999, 1, 0, 32'h11, 32'h22, 0);
        drive(v);
        #2;
        check_outputs("post_reset_lv", v);
        @(negedge CLK);
        v = mk(4'h6, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0);
        drive(v);
        #2;
        check_outputs("post_reset_hist", v);
        check_counters("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1);
    end
endmodule
